// File: rtl/gene_net_analyzer.sv
// 8-gene synchronous Boolean network stepper with sticky attractor flags.
// A one-bit-per-state history bitmap distinguishes cycle re-entry from fixed points.
module gene_net_analyzer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] init_val,
    output logic [7:0] x,
    output logic       fixed,
    output logic       cycle
);

    logic [7:0]   x_q, x_d;
    logic [7:0]   n;
    logic [255:0] visited_q, visited_d;
    logic         fixed_q, fixed_d;
    logic         cycle_q, cycle_d;

    // Regulatory rules; every target reads the pre-edge state.
    always_comb begin
        n    = '0;
        n[0] = x_q[1] & x_q[2];
        n[1] = x_q[0] | x_q[3];
        n[2] = ~x_q[4];
        n[3] = x_q[2] & x_q[5];
        n[4] = x_q[6] ^ x_q[7];
        n[5] = x_q[0] | x_q[4];
        n[6] = x_q[5] & ~x_q[3];
        n[7] = x_q[7];
    end

    // A self-mapping state is a fixed point and never counts as a revisit,
    // so the cycle test is only reached when n differs from x.
    always_comb begin
        visited_d       = visited_q;
        visited_d[x_q]  = 1'b1;
        x_d             = n;
        fixed_d         = fixed_q;
        cycle_d         = cycle_q;
        if (n == x_q) begin
            fixed_d = 1'b1;
        end else if (visited_q[n]) begin
            cycle_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= init_val;
            visited_q <= '0;
            fixed_q   <= 1'b0;
            cycle_q   <= 1'b0;
        end else begin
            x_q       <= x_d;
            visited_q <= visited_d;
            fixed_q   <= fixed_d;
            cycle_q   <= cycle_d;
        end
    end

    assign x     = x_q;
    assign fixed = fixed_q;
    assign cycle = cycle_q;

endmodule

// File: tb/tb_gene_net_analyzer.sv
// Scoreboard bench for gene_net_analyzer: directed hand-computed vectors plus
// an exhaustive sweep of all initial states against a reference network model.
module tb_gene_net_analyzer;

    logic       clk;
    logic       rst;
    logic [7:0] init_val;
    logic [7:0] x;
    logic       fixed;
    logic       cycle;

    gene_net_analyzer dut (
        .clk      (clk),
        .rst      (rst),
        .init_val (init_val),
        .x        (x),
        .fixed    (fixed),
        .cycle    (cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ex;
        logic       ef;
        logic       ec;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state used by the sweep
    logic [7:0] m_x;
    logic       m_f, m_c;
    logic       m_vis [256];

    function automatic logic [7:0] f_ref(input logic [7:0] s);
        logic [7:0] r;
        r[0] = s[1] & s[2];
        r[1] = s[0] | s[3];
        r[2] = ~s[4];
        r[3] = s[2] & s[5];
        r[4] = s[6] ^ s[7];
        r[5] = s[0] | s[4];
        r[6] = s[5] & ~s[3];
        r[7] = s[7];
        return r;
    endfunction

    // Monitor: the DUT presents a new state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (x !== e.ex || fixed !== e.ef || cycle !== e.ec) begin
                    errors++;
                    $display("FAIL %s: got x=%h fixed=%b cycle=%b, expected x=%h fixed=%b cycle=%b",
                             e.name, x, fixed, cycle, e.ex, e.ef, e.ec);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] iv, input logic [7:0] ex,
                        input logic ef, input logic ec, input string name);
        exp_t e;
        @(negedge clk);
        rst      = r;
        init_val = iv;
        e.ex = ex; e.ef = ef; e.ec = ec; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic r, input logic [7:0] iv, input string name);
        logic [7:0] nn;
        if (r) begin
            m_x = iv; m_f = 1'b0; m_c = 1'b0;
            for (int i = 0; i < 256; i++) m_vis[i] = 1'b0;
        end else begin
            nn = f_ref(m_x);
            if (nn == m_x) m_f = 1'b1;
            else if (m_vis[nn]) m_c = 1'b1;
            m_vis[m_x] = 1'b1;
            m_x = nn;
        end
        step(r, iv, m_x, m_f, m_c, name);
    endtask

    initial begin
        logic [7:0] loop_seq [6];
        int n_steps;
        loop_seq[0] = 8'h94; loop_seq[1] = 8'hB0; loop_seq[2] = 8'hF0;
        loop_seq[3] = 8'hE0; loop_seq[4] = 8'hC4; loop_seq[5] = 8'h84;
        rst = 1'b1;
        init_val = 8'h00;

        // Fixed point reached from zero
        step(1, 8'h00, 8'h00, 0, 0, "zero_reset");
        step(0, 8'h00, 8'h04, 0, 0, "zero_edge1");
        step(0, 8'h00, 8'h04, 1, 0, "zero_edge2_fixed");
        step(0, 8'h00, 8'h04, 1, 0, "zero_fixed_sticky");

        // Initial states that are already fixed points
        step(1, 8'h2F, 8'h2F, 0, 0, "imm2F_reset");
        step(0, 8'h2F, 8'h2F, 1, 0, "imm2F_fixed");
        step(1, 8'h04, 8'h04, 0, 0, "imm04_reset");
        step(0, 8'h04, 8'h04, 1, 0, "imm04_fixed");

        // Six-state cycle from 0x80, re-entry on the 7th edge
        step(1, 8'h80, 8'h80, 0, 0, "cyc_reset");
        for (int i = 0; i < 6; i++)
            step(0, 8'h80, loop_seq[i], 0, 0, $sformatf("cyc_edge%0d", i + 1));
        step(0, 8'h80, 8'h94, 0, 1, "cyc_edge7_detect");
        for (int i = 1; i < 6; i++)
            step(0, 8'h80, loop_seq[i], 0, 1, $sformatf("cyc_loop%0d", i));
        step(0, 8'h80, 8'h94, 0, 1, "cyc_loop_wrap");

        // Mid-run reset: stale history from the 0x80 run must not leak
        step(1, 8'h80, 8'h80, 0, 0, "mid_reset80");
        for (int i = 0; i < 3; i++)
            step(0, 8'h80, loop_seq[i], 0, 0, $sformatf("mid_edge%0d", i + 1));
        step(1, 8'h00, 8'h00, 0, 0, "mid_reload00");
        step(0, 8'h00, 8'h04, 0, 0, "mid_edge1");
        step(0, 8'h00, 8'h04, 1, 0, "mid_fixed");
        step(0, 8'h00, 8'h04, 1, 0, "mid_fixed_hold");

        // rst held high reloads each edge; init_val ignored after release
        step(1, 8'h11, 8'h11, 0, 0, "hold_rst1");
        step(1, 8'h22, 8'h22, 0, 0, "hold_rst2");
        step(1, 8'h33, 8'h33, 0, 0, "hold_rst3");
        step(0, 8'hFF, 8'h62, 0, 0, "release_ignore_init");
        step(0, 8'hAA, 8'h54, 0, 0, "release_step2");

        // Exhaustive sweep against the reference model
        for (int v = 0; v < 256; v++) begin
            model_step(1, v[7:0], $sformatf("sweep%0h_reset", v));
            n_steps = 0;
            while (!m_f && !m_c && n_steps < 256) begin
                model_step(0, 8'h00, $sformatf("sweep%0h_s%0d", v, n_steps + 1));
                n_steps++;
            end
            if (!m_f && !m_c) begin
                errors++;
                $display("FAIL sweep%0h_bound: got no attractor, expected one within 256 edges", v);
            end
            model_step(0, 8'h00, $sformatf("sweep%0h_sticky", v));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gene_net_analyzer.md
# gene_net_analyzer

Synchronous 8-gene Boolean gene-regulatory-network simulator with attractor detection. From a loaded initial state it advances the network one step per clock and raises sticky flags when the trajectory reaches a fixed point (a state that maps to itself) or a cycle (a revisit of an earlier state that is not a fixed point). It sits below the initial-value sweep logic, which reads the flags, picks the next `init_val` and pulses `rst`.

## Interface
- Parameters: none. Gene count is 8 and the state space is 256 states.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset/load; loads `init_val` and clears the history.
- `init_val` input 8: initial network state, sampled only on clock edges where `rst`=1.
- `x` output 8: current network state, bit i = gene xi.
- `fixed` output 1: sticky; the trajectory has reached a fixed point.
- `cycle` output 1: sticky; the trajectory has re-entered a previously visited non-fixed state.

## Operation
- Next-state function f(x), with all bits computed from the current x:
  - x0' = x1 & x2
  - x1' = x0 | x3
  - x2' = ~x4
  - x3' = x2 & x5
  - x4' = x6 ^ x7
  - x5' = x0 | x4
  - x6' = x5 & ~x3
  - x7' = x7
- History: `visited[255:0]`, a one-bit-per-state register.
- Edge with `rst`=1:
  - x <= init_val
  - visited <= 0
  - fixed <= 0, cycle <= 0
- Edge with `rst`=0, where n = f(x):
  - visited[x] <= 1
  - x <= n
  - if n == x: fixed <= 1
  - if n != x and (visited[n] or n == x): cycle <= 1. The visited lookup uses the pre-edge bitmap.
- A fixed point never sets `cycle`.
- Flags are sticky until the next `rst`.
- The network keeps stepping after either flag sets. At a fixed point `x` simply holds.
- `fixed` and `cycle` are mutually exclusive within one run.

## Timing
- Reset values:
  - x = init_val (as sampled on the reset edge)
  - fixed = 0, cycle = 0
  - visited all 0
- `x` latency: one state transition per clock. `x` after k non-reset edges equals f^k(init_val).
- `fixed` rises on the first edge where the pre-edge x satisfies f(x) == x. That is the edge after `x` first shows the fixed-point value, or the first edge after reset if `init_val` is itself fixed.
- `cycle` rises on the edge that moves x into an already-visited state. On that same edge `x` shows the re-entry state.
- Worst case: at most 256 non-reset edges before one flag sets, because every trajectory in the finite state space terminates in an attractor.
- `rst` asserted mid-run:
  - Takes effect on that edge and overrides stepping.
  - `rst` held high keeps reloading `init_val`, with flags held at 0.
- `init_val` changes while `rst`=0 are ignored.

## Test plan
- Fixed from zero:
  - rst with init_val=0x00.
  - Edge 1: x=0x04, flags 0.
  - Edge 2: fixed=1, x stays 0x04, cycle=0 thereafter.
- Immediate fixed point:
  - rst with init_val=0x2F.
  - First edge: fixed=1, x=0x2F. Also check 0x04 the same way.
- Cycle detection:
  - rst with init_val=0x80.
  - x sequence: 0x94, 0xB0, 0xF0, 0xE0, 0xC4, 0x84, then 0x94.
  - cycle=1 exactly on the 7th edge. fixed stays 0.
  - Continued stepping repeats the 6-state loop with cycle held at 1.
- Mid-run reset:
  - During the 0x80 run, assert rst with init_val=0x00 after edge 3.
  - x=0x00, flags cleared, then the fixed-point sequence from scenario 1 plays out. The stale visited bits must not trigger a false `cycle`.
- Sticky flags / rst hold:
  - Hold rst=1 for 3 edges while changing init_val.
  - x tracks init_val each edge and flags stay 0.
  - After release, flags persist once set until the next rst.
- Exhaustive sweep:
  - For all 256 init values, run until fixed or cycle.
  - Exactly one flag sets, within 256 edges.
  - x matches a reference model of f at every step.
